// File: rtl/psx_pad_poller.sv
// -----------------------------------------------------------------------------
// psx_pad_poller
//
// Single-clock poller for a DualShock/PSX pad. The pad's SPI-like clock is
// built from a clock-enable sequencer running in the pixel clock domain.
// There is no derived clock. Every POLL_CYCLES clocks a 5-byte frame is
// exchanged. TX bytes are 01 42 00 00 00, sent LSB first. The 16 button bits
// are published active-high, together with the pad ID byte and a connected
// flag.
//
// Handshake/timing contract with the pad:
//   pad_cs is driven low for the whole frame. pad_mosi changes together with
//   the falling edge of pad_clk. pad_miso is sampled on the pixel-clock edge
//   that raises pad_clk, so the pad has a full half period to present each
//   bit after pad_clk falls. The pad ACK line is not used. The inter-byte gap
//   of GAP_HALVES half periods absorbs the pad's ACK delay.
//
// Ports
//   Clk        in   pixel clock, all logic on posedge
//   Reset      in   synchronous, active-high; aborts any frame in progress
//   poll_en    in   1 = start frames when the poll period expires
//   pad_clk    out  pad clock, idles high
//   pad_cs     out  pad select, active-low
//   pad_mosi   out  command data, LSB first, idles high
//   pad_miso   in   pad response data
//   buttons    out  pressed=1, {~rx byte4, ~rx byte3}
//   pad_id     out  rx byte1 of the last good frame
//   connected  out  1 = last frame returned 0x5A in byte2
//   frame_done out  one-cycle pulse at the end of every frame
//   dbg_state  out  current sequencer state (state_t encoding)
// -----------------------------------------------------------------------------
module psx_pad_poller #(
  parameter int SCLK_HALF    = 50,
  parameter int SETUP_HALVES = 2,
  parameter int GAP_HALVES   = 4,
  parameter int POLL_CYCLES  = 420000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        poll_en,
  output logic        pad_clk,
  output logic        pad_cs,
  output logic        pad_mosi,
  input  logic        pad_miso,
  output logic [15:0] buttons,
  output logic [7:0]  pad_id,
  output logic        connected,
  output logic        frame_done,
  output logic [2:0]  dbg_state
);

  // ---------------------------------------------------------------------------
  // Widths and limits
  // ---------------------------------------------------------------------------
  localparam int HC_W     = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int PER_W    = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int HALF_MAX = (SETUP_HALVES > GAP_HALVES) ? SETUP_HALVES : GAP_HALVES;
  localparam int HV_W     = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;

  localparam logic [HC_W-1:0]  HC_LAST    = HC_W'(SCLK_HALF - 1);
  localparam logic [PER_W-1:0] PER_LAST   = PER_W'(POLL_CYCLES - 1);
  localparam logic [HV_W-1:0]  SETUP_LAST = HV_W'(SETUP_HALVES - 1);
  localparam logic [HV_W-1:0]  GAP_LAST   = HV_W'(GAP_HALVES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_LOW   = 3'd2,
    S_HIGH  = 3'd3,
    S_GAP   = 3'd4,
    S_HOLD  = 3'd5
  } state_t;

  // Command bytes: 0x01 = address the pad, 0x42 = poll, then three idle bytes.
  function automatic logic [7:0] tx_byte(input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = 8'h01;
      3'd1:    b = 8'h42;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           state_q,    state_d;
  logic [HC_W-1:0]  hc_q,       hc_d;
  logic [HV_W-1:0]  half_q,     half_d;
  logic [2:0]       byte_q,     byte_d;
  logic [2:0]       bit_q,      bit_d;
  logic [PER_W-1:0] period_q,   period_d;
  logic [7:0]       rx_sr_q,    rx_sr_d;
  logic [7:0]       rx1_q,      rx1_d;
  logic [7:0]       rx2_q,      rx2_d;
  logic [7:0]       rx3_q,      rx3_d;
  logic [7:0]       rx4_q,      rx4_d;
  logic             pad_clk_q,  pad_clk_d;
  logic             pad_cs_q,   pad_cs_d;
  logic             pad_mosi_q, pad_mosi_d;
  logic [15:0]      buttons_q,  buttons_d;
  logic [7:0]       pad_id_q,   pad_id_d;
  logic             conn_q,     conn_d;
  logic             done_q,     done_d;

  logic             tick;
  logic             start;
  logic             enter_low;
  logic [7:0]       tx_sel;

  assign tick  = (hc_q == HC_LAST);
  assign start = (state_q == S_IDLE) && (period_q == '0) && poll_en;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    hc_d       = hc_q;
    half_d     = half_q;
    byte_d     = byte_q;
    bit_d      = bit_q;
    period_d   = period_q;
    rx_sr_d    = rx_sr_q;
    rx1_d      = rx1_q;
    rx2_d      = rx2_q;
    rx3_d      = rx3_q;
    rx4_d      = rx4_q;
    pad_clk_d  = pad_clk_q;
    pad_cs_d   = pad_cs_q;
    pad_mosi_d = pad_mosi_q;
    buttons_d  = buttons_q;
    pad_id_d   = pad_id_q;
    conn_d     = conn_q;
    done_d     = 1'b0;
    enter_low  = 1'b0;
    tx_sel     = 8'h00;

    // Half-period timer runs only inside a frame; it is parked at 0 in IDLE
    // so the first half period after the start is full length.
    if (state_q == S_IDLE) begin
      hc_d = '0;
    end else if (tick) begin
      hc_d = '0;
    end else begin
      hc_d = hc_q + 1'b1;
    end

    // Poll period: reload on a frame start, otherwise count down and stick
    // at 0. A period that expires mid-frame is then honoured on the first
    // IDLE cycle.
    if (start) begin
      period_d = PER_LAST;
    end else if (period_q != '0) begin
      period_d = period_q - 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        pad_cs_d   = 1'b1;
        pad_clk_d  = 1'b1;
        pad_mosi_d = 1'b1;
        if (start) begin
          pad_cs_d = 1'b0;
          byte_d   = 3'd0;
          bit_d    = 3'd0;
          half_d   = '0;
          state_d  = S_SETUP;
        end
      end

      S_SETUP: begin
        if (tick) begin
          if (half_q == SETUP_LAST) begin
            half_d    = '0;
            enter_low = 1'b1;
          end else begin
            half_d = half_q + 1'b1;
          end
        end
      end

      S_LOW: begin
        if (tick) begin
          // Rising pad_clk: capture the pad's bit, LSB first.
          pad_clk_d = 1'b1;
          rx_sr_d   = {pad_miso, rx_sr_q[7:1]};
          state_d   = S_HIGH;
        end
      end

      S_HIGH: begin
        if (tick) begin
          if (bit_q != 3'd7) begin
            bit_d     = bit_q + 3'd1;
            enter_low = 1'b1;
          end else begin
            // rx_sr already holds all 8 bits; byte 0 carries nothing useful.
            case (byte_q)
              3'd1:    rx1_d = rx_sr_q;
              3'd2:    rx2_d = rx_sr_q;
              3'd3:    rx3_d = rx_sr_q;
              3'd4:    rx4_d = rx_sr_q;
              default: ;
            endcase
            if (byte_q != 3'd4) begin
              half_d     = '0;
              pad_mosi_d = 1'b1;
              state_d    = S_GAP;
            end else begin
              state_d = S_HOLD;
            end
          end
        end
      end

      S_GAP: begin
        pad_clk_d  = 1'b1;
        pad_mosi_d = 1'b1;
        if (tick) begin
          if (half_q == GAP_LAST) begin
            half_d    = '0;
            byte_d    = byte_q + 3'd1;
            bit_d     = 3'd0;
            enter_low = 1'b1;
          end else begin
            half_d = half_q + 1'b1;
          end
        end
      end

      S_HOLD: begin
        if (tick) begin
          pad_cs_d = 1'b1;
          done_d   = 1'b1;
          state_d  = S_IDLE;
          // All result outputs change on the same edge as frame_done.
          if (rx2_q == 8'h5A) begin
            buttons_d = ~{rx4_q, rx3_q};
            pad_id_d  = rx1_q;
            conn_d    = 1'b1;
          end else begin
            buttons_d = 16'h0000;
            conn_d    = 1'b0;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Falling pad_clk and the next command bit leave together, after the
    // counters have been updated for the bit about to be sent.
    if (enter_low) begin
      tx_sel     = tx_byte(byte_d);
      pad_clk_d  = 1'b0;
      pad_mosi_d = tx_sel[bit_d];
      state_d    = S_LOW;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      hc_q       <= '0;
      half_q     <= '0;
      byte_q     <= 3'd0;
      bit_q      <= 3'd0;
      period_q   <= PER_LAST;
      rx_sr_q    <= 8'h00;
      rx1_q      <= 8'h00;
      rx2_q      <= 8'h00;
      rx3_q      <= 8'h00;
      rx4_q      <= 8'h00;
      pad_clk_q  <= 1'b1;
      pad_cs_q   <= 1'b1;
      pad_mosi_q <= 1'b1;
      buttons_q  <= 16'h0000;
      pad_id_q   <= 8'h00;
      conn_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hc_q       <= hc_d;
      half_q     <= half_d;
      byte_q     <= byte_d;
      bit_q      <= bit_d;
      period_q   <= period_d;
      rx_sr_q    <= rx_sr_d;
      rx1_q      <= rx1_d;
      rx2_q      <= rx2_d;
      rx3_q      <= rx3_d;
      rx4_q      <= rx4_d;
      pad_clk_q  <= pad_clk_d;
      pad_cs_q   <= pad_cs_d;
      pad_mosi_q <= pad_mosi_d;
      buttons_q  <= buttons_d;
      pad_id_q   <= pad_id_d;
      conn_q     <= conn_d;
      done_q     <= done_d;
    end
  end

  assign pad_clk    = pad_clk_q;
  assign pad_cs     = pad_cs_q;
  assign pad_mosi   = pad_mosi_q;
  assign buttons    = buttons_q;
  assign pad_id     = pad_id_q;
  assign connected  = conn_q;
  assign frame_done = done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_psx_pad_poller.sv
// -----------------------------------------------------------------------------
// tb_psx_pad_poller
//
// Bench for psx_pad_poller. It uses two instances:
//   dut   : SCLK_HALF=2, SETUP_HALVES=2, GAP_HALVES=4, POLL_CYCLES=400.
//           It talks to a pad model that replays a 5-byte response.
//   dut_b : the same, but POLL_CYCLES=100. The period is shorter than a
//           frame, so frames run back to back.
// Frame length = (SETUP + 5 bytes * 16 halves + 4 * GAP + 1 hold) * SCLK_HALF.
// -----------------------------------------------------------------------------
module tb_psx_pad_poller;

  localparam int SCLK_HALF    = 2;
  localparam int SETUP_HALVES = 2;
  localparam int GAP_HALVES   = 4;
  localparam int POLL_A       = 400;
  localparam int POLL_B       = 100;
  localparam int FRAME_LEN    = (SETUP_HALVES + 5 * 16 + 4 * GAP_HALVES + 1) * SCLK_HALF;
  localparam logic [39:0] EXP_MOSI = {8'h00, 8'h00, 8'h00, 8'h42, 8'h01};

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT signals
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        poll_en = 1'b1;
  logic        pad_miso = 1'b1;
  logic        pad_clk, pad_cs, pad_mosi, connected, frame_done;
  logic [15:0] buttons;
  logic [7:0]  pad_id;
  logic [2:0]  dbg_state;

  logic        rst_b = 1'b1;
  logic        poll_b = 1'b1;
  logic        miso_b = 1'b1;
  logic        pad_clk_b, pad_cs_b, pad_mosi_b, connected_b, frame_done_b;
  logic [15:0] buttons_b;
  logic [7:0]  pad_id_b;
  logic [2:0]  dbg_state_b;

  always #5 clk = ~clk;

  psx_pad_poller #(
    .SCLK_HALF(SCLK_HALF), .SETUP_HALVES(SETUP_HALVES),
    .GAP_HALVES(GAP_HALVES), .POLL_CYCLES(POLL_A)
  ) dut (
    .Clk(clk), .Reset(rst), .poll_en(poll_en),
    .pad_clk(pad_clk), .pad_cs(pad_cs), .pad_mosi(pad_mosi), .pad_miso(pad_miso),
    .buttons(buttons), .pad_id(pad_id), .connected(connected),
    .frame_done(frame_done), .dbg_state(dbg_state)
  );

  psx_pad_poller #(
    .SCLK_HALF(SCLK_HALF), .SETUP_HALVES(SETUP_HALVES),
    .GAP_HALVES(GAP_HALVES), .POLL_CYCLES(POLL_B)
  ) dut_b (
    .Clk(clk), .Reset(rst_b), .poll_en(poll_b),
    .pad_clk(pad_clk_b), .pad_cs(pad_cs_b), .pad_mosi(pad_mosi_b), .pad_miso(miso_b),
    .buttons(buttons_b), .pad_id(pad_id_b), .connected(connected_b),
    .frame_done(frame_done_b), .dbg_state(dbg_state_b)
  );

  // ---------------------------------------------------------------------------
  // Cycle counter, pad model, mosi capture, frame_done monitor
  // ---------------------------------------------------------------------------
  int          cyc = 0;
  int          done_cnt = 0;
  logic [39:0] cur_resp = '1;
  int          miso_idx = 0;
  logic [39:0] mosi_cap = '0;
  int          mosi_cnt = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

  // Pad: restart the response on select, present the next bit after each
  // falling pad_clk.
  always @(negedge pad_cs) begin
    miso_idx = 0;
    mosi_cnt = 0;
  end

  always @(posedge pad_cs) pad_miso = 1'b1;

  always @(negedge pad_clk) begin
    if (pad_cs == 1'b0 && miso_idx < 40) begin
      pad_miso = cur_resp[miso_idx];
      miso_idx++;
    end
  end

  always @(posedge pad_clk) begin
    if (pad_cs == 1'b0 && mosi_cnt < 40) begin
      mosi_cap[mosi_cnt] = pad_mosi;
      mosi_cnt++;
    end
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // 0: dut cs low, 1: dut frame_done, 2: dut_b cs low, 3: dut_b frame_done
  function automatic logic cond(input int which);
    logic c;
    case (which)
      0:       c = (pad_cs == 1'b0);
      1:       c = (frame_done == 1'b1);
      2:       c = (pad_cs_b == 1'b0);
      default: c = (frame_done_b == 1'b1);
    endcase
    return c;
  endfunction

  // Counts negedges until the condition holds; n = -1 when the budget runs out.
  task automatic wait_for(input int which, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cond(which) && n < budget);
    if (!cond(which)) n = -1;
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [39:0] resp;      // {byte4, byte3, byte2, byte1, byte0}
    logic [15:0] exp_buttons;
    logic [7:0]  exp_id;
    logic        exp_conn;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n;
    int fall_cyc;
    int prev_fall;
    int done_cyc;
    int low_cnt;
    int done_before;

    vecs[0] = '{resp: {8'hBF, 8'hFE, 8'h5A, 8'h41, 8'hFF}, exp_buttons: 16'h4001, exp_id: 8'h41, exp_conn: 1'b1};
    vecs[1] = '{resp: {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, exp_buttons: 16'h0000, exp_id: 8'h41, exp_conn: 1'b0};
    vecs[2] = '{resp: {8'hFF, 8'h00, 8'h5A, 8'h73, 8'hFF}, exp_buttons: 16'h00FF, exp_id: 8'h73, exp_conn: 1'b1};
    vecs[3] = '{resp: {8'h00, 8'h00, 8'h00, 8'h12, 8'hFF}, exp_buttons: 16'h0000, exp_id: 8'h73, exp_conn: 1'b0};
    vecs[4] = '{resp: {8'hFF, 8'hFF, 8'h5A, 8'h41, 8'hFF}, exp_buttons: 16'h0000, exp_id: 8'h41, exp_conn: 1'b1};
    vecs[5] = '{resp: {8'h00, 8'h7F, 8'h5A, 8'h41, 8'hFF}, exp_buttons: 16'hFF80, exp_id: 8'h41, exp_conn: 1'b1};

    // --- Reset held 10 cycles ------------------------------------------------
    rst = 1'b1;
    poll_en = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rst_pad_clk", pad_clk, 1'b1);
    check("rst_pad_cs", pad_cs, 1'b1);
    check("rst_pad_mosi", pad_mosi, 1'b1);
    check("rst_buttons", buttons, 16'h0);
    check("rst_pad_id", pad_id, 8'h0);
    check("rst_connected", connected, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    rst = 1'b0;
    prev_fall = 0;

    // --- Frames driven from the table ----------------------------------------
    for (int i = 0; i < 6; i++) begin
      cur_resp = vecs[i].resp;
      wait_for(0, 1000, n);
      fall_cyc = cyc;
      if (i == 0) check("first_cs_fall", n, POLL_A);
      else        check($sformatf("cs_period_%0d", i), fall_cyc - prev_fall, POLL_A);
      prev_fall = fall_cyc;
      wait_for(1, 1000, n);
      check($sformatf("frame_len_%0d", i), n, FRAME_LEN);
      check($sformatf("cs_end_%0d", i), pad_cs, 1'b1);
      check($sformatf("mosi_%0d", i), mosi_cap, EXP_MOSI);
      check($sformatf("buttons_%0d", i), buttons, vecs[i].exp_buttons);
      check($sformatf("pad_id_%0d", i), pad_id, vecs[i].exp_id);
      check($sformatf("connected_%0d", i), connected, vecs[i].exp_conn);
      @(negedge clk);
      check($sformatf("done_pulse_%0d", i), frame_done, 1'b0);
    end

    // --- Reset asserted during byte 2 ----------------------------------------
    wait_for(0, 1000, n);
    check("cs_period_pre_reset", cyc - prev_fall, POLL_A);
    n = 0;
    while (mosi_cnt < 20 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("reached_byte2", (mosi_cnt >= 20) ? 1'b1 : 1'b0, 1'b1);
    done_before = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_pad_cs", pad_cs, 1'b1);
    check("midrst_pad_clk", pad_clk, 1'b1);
    check("midrst_buttons", buttons, 16'h0);
    check("midrst_pad_id", pad_id, 8'h0);
    check("midrst_connected", connected, 1'b0);
    rst = 1'b0;
    wait_for(0, 1000, n);
    check("cs_fall_after_midrst", n, POLL_A);
    check("no_done_after_midrst", done_cnt - done_before, 0);
    fall_cyc = cyc;

    // --- poll_en dropped mid-frame -------------------------------------------
    repeat (50) @(negedge clk);
    poll_en = 1'b0;
    wait_for(1, 1000, n);
    done_cyc = cyc;
    check("pollen_off_frame_len", done_cyc - fall_cyc, FRAME_LEN);
    check("pollen_off_buttons", buttons, 16'hFF80);
    low_cnt = 0;
    repeat (600) begin
      @(negedge clk);
      if (pad_cs !== 1'b1) low_cnt++;
    end
    check("pollen_off_cs_idle", low_cnt, 0);
    poll_en = 1'b1;
    wait_for(0, 20, n);
    check("pollen_on_start", n, 1);
    wait_for(1, 1000, n);
    check("pollen_on_frame_len", n, FRAME_LEN);

    // --- Short poll period: back-to-back frames ------------------------------
    @(negedge clk);
    rst_b = 1'b0;
    wait_for(2, 1000, n);
    check("b_first_cs_fall", n, POLL_B);
    for (int k = 0; k < 2; k++) begin
      wait_for(3, 1000, n);
      check($sformatf("b_frame_len_%0d", k), n, FRAME_LEN);
      check($sformatf("b_cs_high_%0d", k), pad_cs_b, 1'b1);
      check($sformatf("b_connected_%0d", k), connected_b, 1'b0);
      check($sformatf("b_buttons_%0d", k), buttons_b, 16'h0);
      wait_for(2, 20, n);
      check($sformatf("b_idle_gap_%0d", k), n, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
